// File: rtl/video_pattern_gen.sv
// Raster timing (de/hs/vs) plus RGB test patterns on the filter-chain pixel bus.
// Optional build macro VIDEO_PATTERN_GEN_SCROLL_EN scrolls bars/gradient left 1 px per frame.
module video_pattern_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CHK_LOG2    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic [1:0]               mode_i,
    input  logic [3*PIXEL_WIDTH-1:0] color_i,
    output logic [3*PIXEL_WIDTH-1:0] do_o,
    output logic                     de_o,
    output logic                     hs_o,
    output logic                     vs_o,
    output logic                     busy_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int SW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int POS_W   = XW + 3 + SW;
    localparam int CW      = 3 * PIXEL_WIDTH;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic             run, line_last, frame_last, frame_wrap, frame_start;
    logic [HW-1:0]    hcnt_q;
    logic [VW-1:0]    vcnt_q;
    logic [1:0]       mode_q;
    logic [CW-1:0]    color_q;
    logic [POS_W-1:0] pos_q, start_d;
    logic [XW-1:0]    x;
    logic [2:0]       bar;
    logic [31:0]      h32, v32;
    logic             chk_on;
    logic [CW-1:0]    pix_d, do_q;
    logic             de_d, hs_d, vs_d, de_q, hs_q, vs_q;

    // Pixel position {x, bar index, pixel-within-bar}: advanced one pixel at a time so bar
    // boundaries come from a small sub-counter instead of a divide by H_ACTIVE/8.
    function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p);
        logic [XW-1:0]    px;
        logic [2:0]       pb;
        logic [SW-1:0]    ps;
        logic [POS_W-1:0] r;
        {px, pb, ps} = p;
        if (px == XW'(H_ACTIVE - 1))
            r = '0;
        else if (ps == SW'(BAR_W - 1))
            r = {XW'(px + 1'b1), 3'(pb + 1'b1), SW'(0)};
        else
            r = {XW'(px + 1'b1), pb, SW'(ps + 1'b1)};
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en_i) state_d = S_RUN;
            S_RUN:   if (frame_last && !en_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run    = (state_q == S_RUN);
        busy_o = run;
    end

    assign line_last   = (hcnt_q == HW'(H_TOTAL - 1));
    assign frame_last  = run && line_last && (vcnt_q == VW'(V_TOTAL - 1));
    assign frame_wrap  = frame_last && en_i;
    assign frame_start = (!run && en_i) || frame_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            pos_q   <= '0;
            mode_q  <= '0;
            color_q <= '0;
        end else begin
            if (frame_start) begin
                mode_q  <= mode_i;
                color_q <= color_i;
            end
            if (!run) begin
                hcnt_q <= '0;
                vcnt_q <= '0;
                pos_q  <= '0;
            end else if (line_last) begin
                hcnt_q <= '0;
                vcnt_q <= frame_last ? '0 : vcnt_q + 1'b1;
                pos_q  <= start_d;
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
                if (32'(hcnt_q) < H_ACTIVE) pos_q <= pos_step(pos_q);
            end
        end
    end

`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
    logic [15:0]      frame_q;
    logic [POS_W-1:0] start_q;

    // start_q tracks (frame_q mod H_ACTIVE); the 16-bit roll-over restarts it at 0.
    always_comb begin
        start_d = start_q;
        if (!run)
            start_d = '0;
        else if (frame_wrap)
            start_d = (frame_q == 16'hFFFF) ? '0 : pos_step(start_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            start_q <= '0;
        end else begin
            start_q <= start_d;
            if (!run)            frame_q <= '0;
            else if (frame_wrap) frame_q <= frame_q + 1'b1;
        end
    end
`else
    assign start_d = '0;
`endif

    always_comb begin
        h32    = 32'(hcnt_q);
        v32    = 32'(vcnt_q);
        x      = pos_q[POS_W-1 -: XW];
        bar    = pos_q[SW +: 3];
        chk_on = (((h32 >> CHK_LOG2) ^ (v32 >> CHK_LOG2)) & 32'd1) != 32'd0;
        de_d   = run && (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        hs_d   = run && (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC);
        vs_d   = run && (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC);
        pix_d  = '0;
        if (de_d) begin
            case (mode_q)
                // Bar index bits map straight to channel enables: r=~b1, g=~b2, b=~b0.
                2'd0:    pix_d = {{PIXEL_WIDTH{~bar[0]}}, {PIXEL_WIDTH{~bar[2]}}, {PIXEL_WIDTH{~bar[1]}}};
                2'd1:    pix_d = {3{PIXEL_WIDTH'(x)}};
                2'd2:    pix_d = {CW{chk_on}};
                default: pix_d = color_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_q <= '0;
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            do_q <= pix_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign do_o = do_q;
    assign de_o = de_q;
    assign hs_o = hs_q;
    assign vs_o = vs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: frame-position reference model checked every cycle,
// plus directed frame, en-drop and mid-frame reset scenarios and a random phase.
module tb_video_pattern_gen;
    localparam int PW  = 8;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int CHK = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i = 1'b0;
    logic [1:0]    mode_i = '0;
    logic [3*PW-1:0] color_i = '0;
    logic [3*PW-1:0] do_o;
    logic          de_o, hs_o, vs_o, busy_o;

    int n_chk  = 0;
    int n_fail = 0;
    int de_cnt = 0;

    // Reference model: a running flag and a linear position t within the frame.
    bit          m_run   = 1'b0;
    int          m_t     = 0;
    int          m_mode  = 0;
    int          m_frame = 0;
    logic [23:0] m_color = '0;
    logic [23:0] exp_do  = '0;
    logic        exp_de = 1'b0, exp_hs = 1'b0, exp_vs = 1'b0, exp_busy = 1'b0;

    video_pattern_gen #(
        .PIXEL_WIDTH(PW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .CHK_LOG2(CHK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i), .color_i(color_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int b);
        case (b)
            0:       return 24'hFFFFFF;  // white
            1:       return 24'h00FFFF;  // yellow {b,g,r}
            2:       return 24'hFFFF00;  // cyan
            3:       return 24'h00FF00;  // green
            4:       return 24'hFF00FF;  // magenta
            5:       return 24'h0000FF;  // red
            6:       return 24'hFF0000;  // blue
            default: return 24'h000000;  // black
        endcase
    endfunction

    function automatic void model_pix(input int t, input int mode, input logic [23:0] col,
                                      input int frame, output logic [23:0] pix,
                                      output logic de, output logic hs, output logic vs);
        int h, v, x;
        logic [7:0] g;
        h = t % HT;
        v = t / HT;
        x = h;
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
        x = (h + frame) % HA;
`endif
        g   = 8'(x);
        de  = (h < HA) && (v < VA);
        hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
        vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
        pix = '0;
        if (de) begin
            case (mode)
                0:       pix = bar_rgb(x / (HA / 8));
                1:       pix = {g, g, g};
                2:       pix = ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
                default: pix = col;
            endcase
        end
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 1'b0; m_t = 0; m_frame = 0;
            exp_do = '0; exp_de = 1'b0; exp_hs = 1'b0; exp_vs = 1'b0; exp_busy = 1'b0;
        end else begin
            if (m_run) model_pix(m_t, m_mode, m_color, m_frame, exp_do, exp_de, exp_hs, exp_vs);
            else begin exp_do = '0; exp_de = 1'b0; exp_hs = 1'b0; exp_vs = 1'b0; end
            if (!m_run) begin
                if (en_i) begin
                    m_run = 1'b1; m_t = 0; m_frame = 0; m_mode = int'(mode_i); m_color = color_i;
                end
            end else if (m_t == FT - 1) begin
                if (en_i) begin
                    m_t = 0; m_frame++; m_mode = int'(mode_i); m_color = color_i;
                end else begin
                    m_run = 1'b0; m_t = 0;
                end
            end else begin
                m_t++;
            end
            exp_busy = m_run;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("do", do_o, exp_do);
        chk("de", de_o, exp_de);
        chk("hs", hs_o, exp_hs);
        chk("vs", vs_o, exp_vs);
        chk("busy", busy_o, exp_busy);
        if (de_o) de_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pos(input int t);
        int k;
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (!(m_run && m_t == t) && k < 2 * FT);
        chk("wait_pos", 32'(m_run && m_t == t), 32'd1);
    endtask

    task automatic run_frame();
        wait_pos(0);
        de_cnt = 0;
        wait_pos(FT - 1);
        chk("frame_de", de_cnt, HA * VA);
    endtask

    initial begin
        int k;
        cyc(4);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_do", do_o, '0);
        rst_n = 1'b1;
        cyc(2);

        mode_i  = 2'd0;
        color_i = 24'($urandom);
        en_i    = 1'b1;
        repeat (4) run_frame();

        mode_i = 2'd1;
        run_frame();
        mode_i = 2'd2;
        run_frame();
        mode_i  = 2'd3;
        color_i = 24'($urandom);
        run_frame();

        // Mode change mid-frame must not show until the next frame.
        wait_pos(0);
        wait_pos(2 * HT + 5);
        mode_i  = 2'd0;
        color_i = 24'($urandom);
        wait_pos(FT - 1);
        run_frame();

        // en dropped on line 1: the frame still completes, then idle.
        wait_pos(0);
        de_cnt = 0;
        wait_pos(HT);
        en_i = 1'b0;
        k = 0;
        while (busy_o && k < 2 * FT) begin
            cyc(1);
            k++;
        end
        chk("drop_idle", busy_o, 1'b0);
        chk("drop_de", de_cnt, HA * VA);
        cyc(5);
        mode_i = 2'($urandom_range(0, 3));
        en_i   = 1'b1;
        run_frame();

        repeat (1500) begin
            cyc(1);
            if ($urandom_range(0, 9) == 0) mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) color_i = 24'($urandom);
            if ($urandom_range(0, 49) == 0) en_i = ~en_i;
        end
        en_i = 1'b1;

        // Asynchronous reset in the middle of line 2.
        wait_pos(2 * HT + 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_do", do_o, '0);
        chk("arst_de", de_o, 1'b0);
        chk("arst_hs", hs_o, 1'b0);
        chk("arst_vs", vs_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        en_i = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        chk("restart_idle", busy_o, 1'b0);
        mode_i = 2'd0;
        en_i   = 1'b1;
        repeat (4) run_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
